// File: rtl/ram_march_ctrl_if.sv
// ram_march_ctrl_if: RAM read/write port bundle between the march sequencer
// (master) and the memory under test (slave).
interface ram_march_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic [DW-1:0] mem_o;
   logic [DW-1:0] mem_d;
   logic [AW-1:0] mem_addr;
   logic          mem_r;
   logic          mem_w;
   modport master (input mem_o, output mem_d, mem_addr, mem_r, mem_w);
   modport slave  (output mem_o, input mem_d, mem_addr, mem_r, mem_w);
endinterface

// File: rtl/ram_march_ctrl.sv
// ram_march_ctrl: two-pass write/read-back self test of a RAM with an
// address-derived pattern, inverted on the second pass; reports errors.
module ram_march_ctrl #(
   parameter int             AW        = 8,
   parameter int             DW        = 16,
   parameter int             LAST_ADDR = 255,
   parameter logic [DW-1:0]  SEED      = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   ram_march_ctrl_if.master    mem,
   output logic                busy,
   output logic                done,
   output logic                pass_ok,
   output logic [15:0]         err_cnt,
   output logic                err_valid,
   output logic [AW-1:0]       first_err_addr,
   output logic                first_err_pass
);
   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
   state_t        state, nxt;
   logic [AW-1:0] addr;
   logic          pass;
   logic          last;
   logic          go;
   logic          mis;
   logic [DW-1:0] pat;
   assign pat  = DW'({addr, ~addr}) ^ SEED ^ {DW{pass}};
   assign last = addr == AW'(LAST_ADDR);
   // abort wins over start, and start is only honoured when not busy
   assign go   = start && !abort && (state == IDLE || state == DONE);
   assign mis  = state == RD && !abort && mem.mem_o != pat;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: nxt = go ? WR : state;
         WR:         nxt = abort ? IDLE : last ? RD : WR;
         RD:         nxt = abort ? IDLE : !last ? RD : pass ? DONE : WR;
         default:    nxt = IDLE;
      endcase
   end
   always_comb begin
      busy         = state == WR || state == RD;
      done         = state == DONE;
      pass_ok      = state == DONE && err_cnt == 16'd0;
      mem.mem_w    = state == WR;
      mem.mem_r    = state == RD;
      mem.mem_addr = addr;
      mem.mem_d    = state == WR ? pat : '0;
   end
   // address wraps to 0 on every phase change, abort, and outside a run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr           <= '0;
         pass           <= 1'b0;
         err_cnt        <= 16'd0;
         err_valid      <= 1'b0;
         first_err_addr <= '0;
         first_err_pass <= 1'b0;
      end else begin
         addr <= (busy && !abort && !last) ? addr + 1'b1 : '0;
         pass <= go ? 1'b0 : (state == RD && last && !abort) ? 1'b1 : pass;
         if (go) begin
            err_cnt        <= 16'd0;
            err_valid      <= 1'b0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
         end else if (mis) begin
            err_cnt <= &err_cnt ? err_cnt : err_cnt + 16'd1;
            if (!err_valid) begin
               err_valid      <= 1'b1;
               first_err_addr <= addr;
               first_err_pass <= pass;
            end
         end
      end
   end
endmodule
